// File: rtl/sram_arb_pkg.sv
// +-----------------------------------------------------------------------------+
// | sram_arb_pkg : shared encodings for the two-port to one-port SRAM arbiter   |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
`default_nettype none

package sram_arb_pkg;

    // Acknowledgement state: who sees ready in the current cycle
    localparam logic [1:0] RESP_NONE = 2'b00;
    localparam logic [1:0] RESP_I    = 2'b01;
    localparam logic [1:0] RESP_D    = 2'b10;

    typedef logic gnt_t;

    localparam gnt_t GNT_I = 1'b0;
    localparam gnt_t GNT_D = 1'b1;

endpackage

`default_nettype wire

// File: rtl/sram_arbiter_if.sv
// +-----------------------------------------------------------------------------+
// | sram_arbiter_if : instruction bus, data bus and SRAM port bundle            |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
`default_nettype none

interface sram_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic              i_valid;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_wdata;
    logic [STRB_W-1:0] i_wstrb;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ready;

    logic              d_valid;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [STRB_W-1:0] d_wstrb;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;

    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [STRB_W-1:0] mem_we;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    // Arbiter view: serves both CPU buses and drives the SRAM macro
    modport slave (
        input  i_valid, i_addr, i_wdata, i_wstrb,
        output i_rdata, i_ready,
        input  d_valid, d_addr, d_wdata, d_wstrb,
        output d_rdata, d_ready,
        output mem_en, mem_addr, mem_we, mem_din,
        input  mem_dout
    );

    modport master (
        output i_valid, i_addr, i_wdata, i_wstrb,
        input  i_rdata, i_ready,
        output d_valid, d_addr, d_wdata, d_wstrb,
        input  d_rdata, d_ready,
        input  mem_en, mem_addr, mem_we, mem_din,
        output mem_dout
    );

endinterface

`default_nettype wire

// File: rtl/sram_arb_sel.sv
// +-----------------------------------------------------------------------------+
// | sram_arb_sel : grant selector; SRAM_ARB_RR_EN selects round-robin on        |
// | conflict, otherwise the data bus has fixed priority.  Rev 1.0               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module sram_arb_sel
    import sram_arb_pkg::*;
(
    input  logic i_inst_elig,
    input  logic i_data_elig,
    input  gnt_t i_last_grant,
    output logic o_gnt_valid,
    output gnt_t o_gnt
);

    always_comb begin
        o_gnt_valid = i_inst_elig | i_data_elig;
`ifdef SRAM_ARB_RR_EN
        if (i_inst_elig && i_data_elig)
            o_gnt = (i_last_grant == GNT_I) ? GNT_D : GNT_I;
`else
        if (i_inst_elig && i_data_elig)
            o_gnt = GNT_D;
`endif
        else if (i_inst_elig)
            o_gnt = GNT_I;
        else
            o_gnt = GNT_D;
    end

`ifndef SRAM_ARB_RR_EN
    // Fixed priority has no history; keep the port shape identical across builds
    logic w_unused_last_grant;
    assign w_unused_last_grant = i_last_grant;
`endif

endmodule

`default_nettype wire

// File: rtl/sram_arbiter.sv
// +-----------------------------------------------------------------------------+
// | sram_arbiter : shares one single-port SRAM between instruction and data    |
// | buses; SRAM_ARB_RR_EN enables round-robin conflict resolution.  Rev 1.0    |
// +-----------------------------------------------------------------------------+
`default_nettype none

module sram_arbiter
    import sram_arb_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    sram_arbiter_if.slave bus
);

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       w_inst_elig;
    logic       w_data_elig;
    logic       w_gnt_valid;
    gnt_t       w_gnt;
    gnt_t       w_last_grant;

    // The requester being acknowledged may still show its old valid; skip it
    assign w_inst_elig = bus.i_valid && (state_q != RESP_I);
    assign w_data_elig = bus.d_valid && (state_q != RESP_D);

    sram_arb_sel u_sel (
        .i_inst_elig  (w_inst_elig),
        .i_data_elig  (w_data_elig),
        .i_last_grant (w_last_grant),
        .o_gnt_valid  (w_gnt_valid),
        .o_gnt        (w_gnt)
    );

    always_comb begin
        state_d = RESP_NONE;
        if (w_gnt_valid)
            state_d = (w_gnt == GNT_I) ? RESP_I : RESP_D;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= RESP_NONE;
        else
            state_q <= state_d;
    end

`ifdef SRAM_ARB_RR_EN
    gnt_t last_grant_q;
    gnt_t last_grant_d;

    always_comb begin
        last_grant_d = last_grant_q;
        if (w_gnt_valid)
            last_grant_d = w_gnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_grant_q <= GNT_I;
        else
            last_grant_q <= last_grant_d;
    end

    assign w_last_grant = last_grant_q;
`else
    assign w_last_grant = GNT_I;
`endif

    // Idle cycles park the address/data mux on the data bus
    always_comb begin
        bus.mem_en   = w_gnt_valid && !rst;
        bus.mem_addr = bus.d_addr;
        bus.mem_din  = bus.d_wdata;
        bus.mem_we   = '0;
        if (w_gnt_valid && (w_gnt == GNT_I)) begin
            bus.mem_addr = bus.i_addr;
            bus.mem_din  = bus.i_wdata;
        end
        if (bus.mem_en)
            bus.mem_we = (w_gnt == GNT_I) ? bus.i_wstrb : bus.d_wstrb;
    end

    assign bus.i_ready = (state_q == RESP_I);
    assign bus.d_ready = (state_q == RESP_D);
    assign bus.i_rdata = bus.mem_dout;
    assign bus.d_rdata = bus.mem_dout;

endmodule

`default_nettype wire

// File: tb/tb_sram_arbiter.sv
// +-----------------------------------------------------------------------------+
// | tb_sram_arbiter : scoreboard bench for sram_arbiter with an SRAM model;    |
// | expectations follow SRAM_ARB_RR_EN when it is defined.  Rev 1.0            |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_sram_arbiter;

    typedef struct {
        logic [12:0] addr;
        logic [3:0]  we;
        logic [31:0] din;
    } gnt_exp_t;

    typedef struct {
        logic        chk;
        logic [31:0] data;
    } rsp_exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_arbiter_if #(.ADDR_W(13), .DATA_W(32)) bus ();

    sram_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int ack_i    = 0;
    int ack_d    = 0;

    gnt_exp_t q_gnt[$];
    rsp_exp_t q_i[$];
    rsp_exp_t q_d[$];
    gnt_exp_t mon_g;
    rsp_exp_t mon_r;

    // SRAM macro model with a bench-side preload port
    logic [31:0] sram [0:8191];
    logic        pl_en;
    logic [12:0] pl_addr;
    logic [31:0] pl_data;

    always @(posedge clk) begin
        if (pl_en) begin
            sram[pl_addr] <= pl_data;
        end else if (bus.mem_en) begin
            bus.mem_dout <= sram[bus.mem_addr];
            for (int b = 0; b < 4; b++)
                if (bus.mem_we[b]) sram[bus.mem_addr][8*b +: 8] <= bus.mem_din[8*b +: 8];
        end
    end

    function automatic logic [31:0] init_val(input logic [12:0] a);
        if (a == 13'h10) return 32'hCAFEF00D;
        if (a == 13'h03) return 32'hFFFFFFFF;
        return {16'hA5A5, 3'b000, a};
    endfunction

    // Monitor: pops expected grants and acknowledgements as the DUT produces them
    always @(negedge clk) begin
        if (rst) begin
            n_checks++;
            if (bus.mem_en !== 1'b0 || bus.mem_we !== 4'b0 || bus.i_ready !== 1'b0 || bus.d_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_outputs: got en=%b we=%b irdy=%b drdy=%b want all 0",
                         bus.mem_en, bus.mem_we, bus.i_ready, bus.d_ready);
            end
        end else begin
            if (bus.mem_en === 1'b1) begin
                n_checks++;
                if (q_gnt.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_grant: got addr=%h we=%b want no grant", bus.mem_addr, bus.mem_we);
                end else begin
                    mon_g = q_gnt.pop_front();
                    if (bus.mem_addr !== mon_g.addr || bus.mem_we !== mon_g.we ||
                        (mon_g.we != 4'b0 && bus.mem_din !== mon_g.din)) begin
                        n_errors++;
                        $display("FAIL grant: got addr=%h we=%b din=%h want addr=%h we=%b din=%h",
                                 bus.mem_addr, bus.mem_we, bus.mem_din, mon_g.addr, mon_g.we, mon_g.din);
                    end
                end
            end else begin
                n_checks++;
                if (bus.mem_we !== 4'b0) begin
                    n_errors++;
                    $display("FAIL idle_we: got %b want 0000", bus.mem_we);
                end
            end
            if (bus.i_ready === 1'b1) begin
                ack_i++;
                n_checks++;
                if (q_i.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_i_ready: got 1 want 0");
                end else begin
                    mon_r = q_i.pop_front();
                    if (mon_r.chk && bus.i_rdata !== mon_r.data) begin
                        n_errors++;
                        $display("FAIL i_rdata: got %h want %h", bus.i_rdata, mon_r.data);
                    end
                end
            end
            if (bus.d_ready === 1'b1) begin
                ack_d++;
                n_checks++;
                if (q_d.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_d_ready: got 1 want 0");
                end else begin
                    mon_r = q_d.pop_front();
                    if (mon_r.chk && bus.d_rdata !== mon_r.data) begin
                        n_errors++;
                        $display("FAIL d_rdata: got %h want %h", bus.d_rdata, mon_r.data);
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_rd_i(input logic [12:0] a, input logic [31:0] v);
        q_gnt.push_back('{addr: a, we: 4'b0, din: 32'h0});
        q_i.push_back('{chk: 1'b1, data: v});
    endtask

    task automatic exp_rd_d(input logic [12:0] a, input logic [31:0] v);
        q_gnt.push_back('{addr: a, we: 4'b0, din: 32'h0});
        q_d.push_back('{chk: 1'b1, data: v});
    endtask

    task automatic drain(input string name);
        repeat (3) cyc();
        n_checks++;
        if (q_gnt.size() != 0 || q_i.size() != 0 || q_d.size() != 0) begin
            n_errors++;
            $display("FAIL %s_pending: got gnt=%0d i=%0d d=%0d outstanding want 0",
                     name, q_gnt.size(), q_i.size(), q_d.size());
            q_gnt.delete();
            q_i.delete();
            q_d.delete();
        end
    endtask

    task automatic test_reset();
        logic [12:0] pl_list [9];
        pl_list = '{13'h20, 13'h21, 13'h10, 13'h40, 13'h41, 13'h50, 13'h51, 13'h03, 13'h60};
        // Both requesters already valid while reset is held
        bus.i_valid = 1'b1;
        bus.i_addr  = 13'h21;
        bus.d_valid = 1'b1;
        bus.d_addr  = 13'h20;
        for (int k = 0; k < 9; k++) begin
            cyc();
            pl_en   = 1'b1;
            pl_addr = pl_list[k];
            pl_data = init_val(pl_list[k]);
        end
        cyc();
        pl_en = 1'b0;
        rst   = 1'b0;
        exp_rd_d(13'h20, init_val(13'h20));
        cyc();
        bus.d_valid = 1'b0;
        exp_rd_i(13'h21, init_val(13'h21));
        cyc();
        bus.i_valid = 1'b0;
        drain("reset");
    endtask

    task automatic test_single_read();
        cyc();
        bus.i_valid = 1'b1;
        bus.i_addr  = 13'h10;
        exp_rd_i(13'h10, 32'hCAFEF00D);
        cyc();
        cyc();
        // Valid held through the ready cycle is a fresh request, granted one cycle later
        exp_rd_i(13'h10, 32'hCAFEF00D);
        cyc();
        bus.i_valid = 1'b0;
        drain("single_read");
    endtask

    task automatic test_back_to_back();
        ack_i = 0;
        ack_d = 0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            if (k == 0) begin
                bus.i_valid = 1'b1;
                bus.i_addr  = 13'h40;
                bus.d_valid = 1'b1;
                bus.d_addr  = 13'h41;
            end
            if (k == 7) bus.d_valid = 1'b0;
            if (k % 2 == 0) exp_rd_d(13'h41, init_val(13'h41));
            else            exp_rd_i(13'h40, init_val(13'h40));
        end
        cyc();
        bus.i_valid = 1'b0;
        drain("back_to_back");
        n_checks++;
        if (ack_i != 4 || ack_d != 4) begin
            n_errors++;
            $display("FAIL back_to_back_acks: got i=%0d d=%0d want i=4 d=4", ack_i, ack_d);
        end
    endtask

    task automatic test_conflict();
        bus.i_addr = 13'h50;
        bus.d_addr = 13'h51;
        cyc();
        bus.d_valid = 1'b1;
        exp_rd_d(13'h51, init_val(13'h51));
        cyc();
        bus.d_valid = 1'b0;
        cyc();
        // Conflict right after a data grant: the policy decides the winner
        bus.d_valid = 1'b1;
        bus.i_valid = 1'b1;
`ifdef SRAM_ARB_RR_EN
        exp_rd_i(13'h50, init_val(13'h50));
        cyc();
        bus.i_valid = 1'b0;
        exp_rd_d(13'h51, init_val(13'h51));
        cyc();
        bus.d_valid = 1'b0;
`else
        exp_rd_d(13'h51, init_val(13'h51));
        cyc();
        bus.d_valid = 1'b0;
        exp_rd_i(13'h50, init_val(13'h50));
        cyc();
        bus.i_valid = 1'b0;
`endif
        drain("conflict");
    endtask

    task automatic test_write();
        cyc();
        bus.d_valid = 1'b1;
        bus.d_addr  = 13'h03;
        bus.d_wstrb = 4'b0011;
        bus.d_wdata = 32'h12345678;
        q_gnt.push_back('{addr: 13'h03, we: 4'b0011, din: 32'h12345678});
        q_d.push_back('{chk: 1'b0, data: 32'h0});
        cyc();
        bus.d_valid = 1'b0;
        bus.d_wstrb = 4'b0000;
        bus.d_wdata = 32'h0;
        cyc();
        bus.d_valid = 1'b1;
        exp_rd_d(13'h03, 32'hFFFF5678);
        cyc();
        bus.d_valid = 1'b0;
        drain("write");
    endtask

    task automatic test_rst_mid();
        cyc();
        bus.i_valid = 1'b1;
        bus.i_addr  = 13'h60;
        q_gnt.push_back('{addr: 13'h60, we: 4'b0, din: 32'h0});
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        exp_rd_i(13'h60, init_val(13'h60));
        cyc();
        bus.i_valid = 1'b0;
        drain("rst_mid");
    endtask

    initial begin
        rst         = 1'b1;
        pl_en       = 1'b0;
        pl_addr     = '0;
        pl_data     = '0;
        bus.i_valid = 1'b0;
        bus.i_addr  = '0;
        bus.i_wdata = '0;
        bus.i_wstrb = '0;
        bus.d_valid = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        bus.d_wstrb = '0;
        test_reset();
        test_single_read();
        test_back_to_back();
        test_conflict();
        test_write();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port to single-port arbiter that shares one single-port SRAM macro between the CPU instruction bus and data bus. It accepts valid/ready requests from both buses and issues at most one SRAM access per cycle. It returns each ready and read word exactly one cycle after the access is granted. It sits between the CPU/boot bus interconnect and the SRAM macro, in place of a dual-port memory on targets without one.

## Interface
- ADDR_W, default 13: word address width (`SRAM_ADDR_W-2`).
- DATA_W, default 32: data width; strobe width is DATA_W/8.
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- i_valid, i_addr, i_wdata, i_wstrb  in  1/ADDR_W/DATA_W/DATA_W/8  instruction request; wstrb nonzero only during boot.
- i_rdata  out  DATA_W  instruction read data.
- i_ready  out  1  instruction completion pulse.
- d_valid, d_addr, d_wdata, d_wstrb  in  1/ADDR_W/DATA_W/DATA_W/8  data request.
- d_rdata  out  DATA_W  data read data.
- d_ready  out  1  data completion pulse.
- mem_en, mem_addr, mem_we, mem_din  out  1/ADDR_W/DATA_W/8/DATA_W  SRAM port.
- mem_dout  in  DATA_W  SRAM read data; valid the cycle after mem_en.

## Operation
- Requester rules: raise valid and hold addr/wdata/wstrb stable until ready is seen high for one cycle. Valid may drop in the ready cycle or stay high for a new request.
- FSM state records which requester is being acknowledged this cycle:
  - RESP_NONE: no acknowledgement this cycle.
  - RESP_I: the instruction requester is acknowledged this cycle.
  - RESP_D: the data requester is acknowledged this cycle.
- Eligibility: a requester is eligible if its valid is high and it is not the one being acknowledged this cycle. This prevents a stale valid being regranted.
- Grant: choose one eligible requester (see Configuration). Drive mem_en=1 and the grantee's addr/wstrb/wdata combinationally onto the SRAM port. Next state is RESP_I or RESP_D accordingly; with no grant, next state is RESP_NONE.
- i_ready=1 in RESP_I and d_ready=1 in RESP_D, both registered from state.
- i_rdata = d_rdata = mem_dout, unmuxed. Content is meaningful only in the owner's ready cycle. For writes the value is don't-care.
- Write: mem_we=wstrb of the grantee; ready is returned exactly as for reads.
- With no grant, mem_en=0, mem_we=0, and addr/din hold the data-bus values.
- Throughput:
  - both buses busy: alternating grants, one access per cycle;
  - single busy requester: one access per two cycles.

## Timing
- Reset values: state RESP_NONE; i_ready=0, d_ready=0; last_grant=I.
- While rst is high, mem_en=0 and mem_we=0 regardless of valid.
- Latency: grant in cycle N, then ready and rdata in N+1. A losing requester waits one more cycle per lost arbitration; worst case is 2 cycles from valid to grant.
- Simultaneous events: valid arriving during the other requester's RESP cycle is granted in that same cycle.
- Reset mid-operation: a pending acknowledgement is discarded, no ready is issued, and the requester must re-present its request.
- No combinational path from mem_dout to any control output.

## Configuration
- SRAM_ARB_RR_EN defined: round-robin on conflict. The requester not in last_grant wins, and last_grant updates on every grant.
- SRAM_ARB_RR_EN undefined: fixed priority, data bus wins every conflict. last_grant is not implemented. Instruction starvation is bounded only by the one-cycle exclusion rule.

## Structure
- sram_arb_pkg holds:
  - state encoding: RESP_NONE=2'b00, RESP_I=2'b01, RESP_D=2'b10;
  - grantee constants: GNT_I, GNT_D.
- One sub-module, sram_arb_sel: a combinational selector from the two eligible flags plus last_grant to the grant, containing the macro-dependent policy.
- The top level holds the FSM, the last_grant register and the SRAM port muxing.

## Test plan
- Reset with i_valid=d_valid=1 held → mem_en=0 during rst; first cycle after release grants D (both configs); d_ready=1 next cycle with d_rdata=mem[d_addr].
- Single read i_addr=0x10, mem[0x10]=0xCAFEF00D → mem_en in cycle N, i_ready=1 and i_rdata=0xCAFEF00D in N+1, no second grant in N+1.
- Both valid continuously for 8 cycles, RR build → grants D,I,D,I,…, one ready per cycle, 4 acks each.
- Same stimulus, non-RR build → grants D,I,D,I (exclusion forces alternation); d_valid held with i_valid pulsed → D always wins the conflict.
- Data write d_addr=0x3, d_wstrb=4'b0011, d_wdata=0x12345678 over 0xFFFFFFFF, then read → mem_we=0011 in grant cycle; read returns 0xFFFF5678.
- rst pulsed in the cycle after a grant → no ready pulses; request re-presented after release completes normally.
